// File: rtl/immed_gen_pipe_if.sv
// Valid/ready bus for the immediate generator: an instruction/tag request
// side and a decoded immediate response side.
interface immed_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_ir;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_ir, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_ir, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/immed_gen_pipe.sv
// Decode-stage immediate generator with a one-cycle output register and a
// one-entry skid buffer so back-pressure never costs throughput.
module immed_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  immed_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    fmt_e             fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  state_e      state, state_n;
  entry_t      out_q, out_n;
  entry_t      skid_q, skid_n;
  entry_t      dec;
  logic [31:0] ir;
  logic [2:0]  f3;
  logic        shift_f3;

  assign ir       = bus.in_ir;
  assign f3       = ir[14:12];
  assign shift_f3 = (f3 == 3'b001) || (f3 == 3'b101);

  // Every legal opcode ends in 2'b11, so a bad ir[1:0] lands in the default.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    dec     = '0;
    dec.tag = bus.in_tag;
    case (ir[6:0])
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = sext32({ir[31:12], 12'b0});
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = sext32({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = sext32({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = sext32({{20{ir[31]}}, ir[31:25], ir[11:7]});
      end
      7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        dec.fmt = FMT_I;
        dec.imm = sext32({{20{ir[31]}}, ir[31:20]});
      end
      7'b0010011: begin
        if (!shift_f3) begin
          dec.fmt = FMT_I;
          dec.imm = sext32({{20{ir[31]}}, ir[31:20]});
        end else if (XLEN == 32 && ir[25]) begin
          dec.illegal = 1'b1;
        end else begin
          dec.fmt      = FMT_SHAMT;
          dec.imm[5:0] = {(XLEN == 64) ? ir[25] : 1'b0, ir[24:20]};
        end
      end
      7'b0011011: begin
        if (XLEN != 64) begin
          dec.illegal = 1'b1;
        end else if (shift_f3) begin
          dec.fmt      = FMT_SHAMT;
          dec.imm[4:0] = ir[24:20];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sext32({{20{ir[31]}}, ir[31:20]});
        end
      end
      7'b0110011: ;
      7'b0111011: dec.illegal = (XLEN != 64);
      default:    dec.illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_n = state;
    out_n   = out_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      out_n   = '0;
      skid_n  = '0;
    end else begin
      case (state)
        EMPTY: if (bus.in_valid) begin
          out_n   = dec;
          state_n = ONE;
        end
        ONE: begin
          if (bus.in_valid && bus.out_ready) begin
            out_n = dec;
          end else if (bus.in_valid) begin
            skid_n  = dec;
            state_n = FULL;
          end else if (bus.out_ready) begin
            state_n = EMPTY;
          end
        end
        FULL: if (bus.out_ready) begin
          out_n   = skid_q;
          state_n = ONE;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      out_q  <= out_n;
      skid_q <= skid_n;
    end
  end

  assign bus.in_ready    = (state != FULL);
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_imm     = out_q.imm;
  assign bus.out_fmt     = out_q.fmt;
  assign bus.out_illegal = out_q.illegal;
  assign bus.out_tag     = out_q.tag;

endmodule

// File: tb/tb_immed_gen_pipe.sv
// Directed bench: a vector table run on XLEN=32 and XLEN=64 instances, then
// back-pressure, flush and asynchronous reset sequences.
module tb_immed_gen_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ir;
  logic [31:0] in_tag;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  immed_gen_pipe_if #(.XLEN(32), .TAG_W(32)) if32 ();
  immed_gen_pipe_if #(.XLEN(64), .TAG_W(32)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.in_ir     = in_ir;
  assign if32.in_tag    = in_tag;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.in_ir     = in_ir;
  assign if64.in_tag    = in_tag;
  assign if64.out_ready = out_ready;

  immed_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if32)
  );

  immed_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addi_ir(input logic [11:0] v);
    return {v, 20'h00093};
  endfunction

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid32"}, if32.out_valid, 0);
    check({tag, "_imm32"},   if32.out_imm, 0);
    check({tag, "_fmt32"},   if32.out_fmt, 0);
    check({tag, "_ill32"},   if32.out_illegal, 0);
    check({tag, "_tag32"},   if32.out_tag, 0);
    check({tag, "_ready32"}, if32.in_ready, 1);
    check({tag, "_valid64"}, if64.out_valid, 0);
    check({tag, "_imm64"},   if64.out_imm, 0);
    check({tag, "_tag64"},   if64.out_tag, 0);
  endtask

  initial begin
    int sent;
    int expn;

    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_ir     = '0;
    in_tag    = '0;
    out_ready = 1'b0;

    //               ir            imm32         f  il  imm64                  f  il
    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h0080006F, 32'h00000008, 3'd5, 1'b0, 64'h0000000000000008, 3'd5, 1'b0};
    vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[4]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[5]  = '{32'h02109093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000021, 3'd6, 1'b0};
    vecs[6]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[7]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[8]  = '{32'h0010809B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd1, 1'b0};
    vecs[9]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[10] = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
    vecs[11] = '{32'h00000013, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[12] = '{32'h00008067, 32'h00000000, 3'd1, 1'b0, 64'h0000000000000000, 3'd1, 1'b0};
    vecs[13] = '{32'h0210909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd6, 1'b0};
    vecs[14] = '{32'hFFF00090, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};

    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back stream with out_ready=1: each vector appears one edge later.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      in_ir     = vecs[i].ir;
      in_tag    = 32'(i + 100);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid32", i), if32.out_valid, 1);
      check($sformatf("v%0d_imm32", i),   if32.out_imm, vecs[i].imm32);
      check($sformatf("v%0d_fmt32", i),   if32.out_fmt, vecs[i].fmt32);
      check($sformatf("v%0d_ill32", i),   if32.out_illegal, vecs[i].ill32);
      check($sformatf("v%0d_tag32", i),   if32.out_tag, 64'(i + 100));
      check($sformatf("v%0d_imm64", i),   if64.out_imm, vecs[i].imm64);
      check($sformatf("v%0d_fmt64", i),   if64.out_fmt, vecs[i].fmt64);
      check($sformatf("v%0d_ill64", i),   if64.out_illegal, vecs[i].ill64);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("drain_valid", if32.out_valid, 0);

    // Back-pressure: tags 1..4, out_ready held low for the first six cycles.
    sent = 1;
    expn = 1;
    for (int cyc = 0; cyc < 30 && expn <= 4; cyc++) begin
      @(negedge clk);
      in_valid  = (sent <= 4);
      in_tag    = 32'(sent);
      in_ir     = addi_ir(sent[11:0]);
      out_ready = (cyc >= 6);
      #1;
      if (cyc >= 2 && cyc <= 5) begin
        check("bp_in_ready_low", if32.in_ready, 0);
        check("bp_hold_valid",   if32.out_valid, 1);
        check("bp_hold_tag",     if32.out_tag, 1);
        check("bp_hold_imm",     if32.out_imm, 1);
      end
      if (if32.out_valid && out_ready) begin
        check("bp_order_tag", if32.out_tag, 64'(expn));
        check("bp_order_imm", if32.out_imm, 64'(expn));
        check("bp_order_tag64", if64.out_tag, 64'(expn));
        expn++;
      end
      if (in_valid && if32.in_ready) sent++;
    end
    check("bp_all_delivered", 64'(expn), 5);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_empty_after", if32.out_valid, 0);

    // Flush while FULL with an input presented: everything is dropped.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 32'd10;
    in_ir     = addi_ir(12'd10);
    @(negedge clk);
    in_tag = 32'd11;
    in_ir  = addi_ir(12'd11);
    @(negedge clk);
    in_tag = 32'd12;
    in_ir  = addi_ir(12'd12);
    flush  = 1'b1;
    #1;
    check("fl_full_ready", if32.in_ready, 0);
    @(posedge clk);
    #1;
    check("fl_full_valid", if32.out_valid, 0);
    check("fl_full_ready_after", if32.in_ready, 1);
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("fl_no_leak", if32.out_valid, 0);
    end

    // Flush in ONE: the pending output handshake completes, new input dropped.
    @(negedge clk);
    in_valid  = 1'b1;
    in_tag    = 32'd20;
    in_ir     = addi_ir(12'd20);
    out_ready = 1'b0;
    @(negedge clk);
    in_tag    = 32'd21;
    in_ir     = addi_ir(12'd21);
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("fl_one_out_valid", if32.out_valid, 1);
    check("fl_one_out_tag",   if32.out_tag, 20);
    @(posedge clk);
    #1;
    check("fl_one_cleared", if32.out_valid, 0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fl_one_dropped", if32.out_valid, 0);

    // Asynchronous reset asserted between clock edges.
    @(negedge clk);
    in_valid  = 1'b1;
    in_tag    = 32'd30;
    in_ir     = 32'hFFF00093;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("rst_pre_valid", if32.out_valid, 1);
    check("rst_pre_tag",   if32.out_tag, 30);
    rst = 1'b1;
    #1;
    check_zero_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_post_valid", if32.out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/immed_gen_pipe.md
Name: immed_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage.
- Accepts a 32-bit instruction word plus a sideband tag over a valid/ready handshake.
- Decodes the opcode to choose a single format and emits one XLEN-wide, correctly extended immediate, a format code and an illegal flag.
- Has a one-cycle pipeline register and a one-entry skid buffer, so full throughput is kept under downstream back-pressure. Also supports shift-amount immediates, RV64 sign extension and a flush.

Parameters:
- XLEN, 32, immediate width; legal values are 32 or 64.
- TAG_W, 32, width of the sideband tag (typically the PC) carried alongside each instruction.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  block can accept; registered.
- in_ir  in  32  instruction word.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format code: 0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT.
- out_illegal  out  1  instruction not decodable.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Reset (asynchronous, RST=1) forces these values:
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Skid buffer empty; in_ready=1.
- A transfer occurs on a rising edge where valid&&ready. Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N, unless the skid buffer is occupied.
- Opcode decode on in_ir[6:0] (sign bit is ir[31]; sign extension is to XLEN):
  - 0110111 and 0010111: U, value {ir[31:12],12'b0} sign-extended.
  - 1101111: J, {ir[31],ir[19:12],ir[20],ir[30:21],0}.
  - 1100011: B, {ir[31],ir[7],ir[30:25],ir[11:8],0}.
  - 0100011: S, {ir[31:25],ir[11:7]}.
  - 0000011, 1100111, 0001111, 1110011: I, ir[31:20].
  - 0010011: for funct3 001/101 the format is SHAMT. The immediate is ir[24:20] zero-extended when XLEN=32, or ir[25:20] when XLEN=64. Otherwise the format is I.
  - 0011011 (XLEN=64 only): funct3 001/101 gives SHAMT ir[24:20]; otherwise I.
  - 0110011, and 0111011 when XLEN=64: fmt 0, imm 0.
- Illegal conditions:
  - ir[1:0]!=2'b11.
  - Any other opcode.
  - Opcode 0011011/0111011 when XLEN=32.
  - SHAMT with ir[25]=1 when XLEN=32.
  - When illegal: out_illegal=1, fmt=0, imm=0.
- Output/skid control states:
  - EMPTY: no valid entry; in_ready=1.
  - ONE: output register valid, skid empty; in_ready=1.
  - FULL: output register and skid both valid; in_ready=0.
- State transitions:
  - EMPTY + accept → ONE.
  - ONE + accept + out_ready → ONE, with the new entry in the output register.
  - ONE + accept + !out_ready → FULL, with the new entry in the skid.
  - ONE + !accept + out_ready → EMPTY.
  - FULL + out_ready → ONE, with the skid moving to the output register.
  - FULL never accepts input.
- Order is strictly preserved. While out_valid=1 and out_ready=0, out_imm, out_fmt, out_illegal and out_tag hold stable.
- flush=1 at an edge:
  - Both entries are cleared; state goes to EMPTY; in_ready=1 after that edge.
  - An input presented in the same cycle is discarded.
  - An output handshake in the same cycle still completes for the downstream.
- RST asserted mid-operation clears everything immediately, independent of CLK.
- Decode is purely a function of the accepted in_ir. No state depends on instruction history.

Test Plan:
- XLEN=32, in_ir=0xFFF00093 (addi x1,x0,-1), out_ready=1 → one cycle later: out_imm=0xFFFFFFFF, fmt=1, illegal=0.
- XLEN=32, in_ir=0xFE000EE3 (beq -4) → out_imm=0xFFFFFFFC, fmt=3. Then in_ir=0x0080006F (jal +8) → out_imm=0x00000008, fmt=5.
- U-type sign extension:
  - XLEN=64, in_ir=0x800000B7 (lui) → out_imm=0xFFFFFFFF80000000, fmt=4.
  - XLEN=32, in_ir=0x123450B7 → out_imm=0x12345000.
- Shift amount, in_ir=0x02109093 (slli x1,x1,33):
  - XLEN=64 → out_imm=0x21, fmt=6.
  - XLEN=32 → out_illegal=1, out_imm=0.
  - in_ir=0x00000000 → out_illegal=1.
- Back-pressure: stream 4 tagged instructions (tags 1..4) with out_ready held 0.
  - in_ready must drop after the 2nd accept.
  - Release out_ready → tags 1,2,3,4 emerge in order with no loss or duplication; outputs stable while stalled.
- Flush and reset:
  - In FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed tag never appears.
  - Assert RST mid-stream between clock edges → outputs go to zero immediately.
